// File: rtl/seg7_scan_if.sv
// Display-side bundle between the MM:SS counter and the 7-segment scan driver.
interface seg7_scan_if;
  logic [3:0] sec_1s_in;
  logic [3:0] sec_10s_in;
  logic [3:0] min_1s_in;
  logic [3:0] min_10s_in;
  logic       adj;
  logic       sel;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  modport master (
    output sec_1s_in, sec_10s_in, min_1s_in, min_10s_in, adj, sel,
    input  seg, dp, an
  );

  modport slave (
    input  sec_1s_in, sec_10s_in, min_1s_in, min_10s_in, adj, sel,
    output seg, dp, an
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexes four BCD digits onto a common-anode 7-segment display,
// with frame-coherent digit snapshots and blinking of the adjusted field.
module seg7_scan_driver #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 25000000
) (
  input logic        clk_sel,
  input logic        rst,
  seg7_scan_if.slave disp
);

  localparam int unsigned REF_W = $clog2(REFRESH_DIV);
  localparam int unsigned BLK_W = $clog2(BLINK_DIV);

  typedef enum logic [1:0] {
    SLOT_SEC1  = 2'd0,
    SLOT_SEC10 = 2'd1,
    SLOT_MIN1  = 2'd2,
    SLOT_MIN10 = 2'd3
  } slot_t;

  slot_t            idx, idx_next;
  logic [REF_W-1:0] ref_cnt;
  logic             tick;
  logic [BLK_W-1:0] blink_cnt;
  logic             blink_ph;
  logic [3:0]       snap_s1, snap_s10, snap_m1, snap_m10;
  logic [3:0]       cur_digit;
  logic [3:0]       an_d;
  logic             dp_d;
  logic             blank;

  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0:    dec7 = 7'b1000000;
      4'd1:    dec7 = 7'b1111001;
      4'd2:    dec7 = 7'b0100100;
      4'd3:    dec7 = 7'b0110000;
      4'd4:    dec7 = 7'b0011001;
      4'd5:    dec7 = 7'b0010010;
      4'd6:    dec7 = 7'b0000010;
      4'd7:    dec7 = 7'b1111000;
      4'd8:    dec7 = 7'b0000000;
      4'd9:    dec7 = 7'b0010000;
      default: dec7 = 7'b1111111;
    endcase
  endfunction

  assign tick = (ref_cnt == REF_W'(REFRESH_DIV - 1));

  always_ff @(posedge clk_sel or posedge rst) begin
    if (rst)       ref_cnt <= '0;
    else if (tick) ref_cnt <= '0;
    else           ref_cnt <= ref_cnt + 1'b1;
  end

  always_ff @(posedge clk_sel or posedge rst) begin
    if (rst) idx <= SLOT_SEC1;
    else     idx <= idx_next;
  end

  always_comb begin
    idx_next = idx;
    if (tick) begin
      case (idx)
        SLOT_SEC1:  idx_next = SLOT_SEC10;
        SLOT_SEC10: idx_next = SLOT_MIN1;
        SLOT_MIN1:  idx_next = SLOT_MIN10;
        default:    idx_next = SLOT_SEC1;
      endcase
    end
  end

  // Capture only at the frame boundary so one frame never mixes two times.
  always_ff @(posedge clk_sel or posedge rst) begin
    if (rst) begin
      snap_s1  <= '0;
      snap_s10 <= '0;
      snap_m1  <= '0;
      snap_m10 <= '0;
    end else if (tick && idx == SLOT_MIN10) begin
      snap_s1  <= disp.sec_1s_in;
      snap_s10 <= disp.sec_10s_in;
      snap_m1  <= disp.min_1s_in;
      snap_m10 <= disp.min_10s_in;
    end
  end

  // Held at zero outside adjust mode so entry always begins with a visible half.
  always_ff @(posedge clk_sel or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (!disp.adj) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      blink_ph  <= ~blink_ph;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_comb begin
    cur_digit = snap_s1;
    an_d      = 4'b1110;
    dp_d      = 1'b1;
    case (idx)
      SLOT_SEC1:  begin cur_digit = snap_s1;  an_d = 4'b1110; end
      SLOT_SEC10: begin cur_digit = snap_s10; an_d = 4'b1101; end
      SLOT_MIN1:  begin cur_digit = snap_m1;  an_d = 4'b1011; dp_d = 1'b0; end
      default:    begin cur_digit = snap_m10; an_d = 4'b0111; end
    endcase
    blank = disp.adj & blink_ph &
            (disp.sel ? (idx == SLOT_SEC1 || idx == SLOT_SEC10)
                      : (idx == SLOT_MIN1 || idx == SLOT_MIN10));
  end

  always_ff @(posedge clk_sel or posedge rst) begin
    if (rst) begin
      disp.an  <= '1;
      disp.seg <= '1;
      disp.dp  <= 1'b1;
    end else if (blank) begin
      disp.an  <= '1;
      disp.seg <= '1;
      disp.dp  <= 1'b1;
    end else begin
      disp.an  <= an_d;
      disp.seg <= dec7(cur_digit);
      disp.dp  <= dp_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with REFRESH_DIV=4, BLINK_DIV=8; outputs
// are sampled on the falling edge, one slot (4 cycles) at a time.
module tb_seg7_scan_driver;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] SD = 7'b1111111;

  logic        clk_sel = 1'b0;
  logic        rst     = 1'b1;
  int unsigned cyc     = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  seg7_scan_if disp ();

  seg7_scan_driver #(.REFRESH_DIV(4), .BLINK_DIV(8)) dut (
    .clk_sel (clk_sel),
    .rst     (rst),
    .disp    (disp)
  );

  always #5 clk_sel = ~clk_sel;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %b expected %b", tag, cyc, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_sel);
    @(negedge clk_sel);
    cyc++;
  endtask

  task automatic slot(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e,
                      input logic dp_e, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      next_cycle();
      chk({tag, " an"},  {4'h0, disp.an},  {4'h0, an_e});
      chk({tag, " seg"}, {1'b0, disp.seg}, {1'b0, seg_e});
      chk({tag, " dp"},  {7'h0, disp.dp},  {7'h0, dp_e});
    end
  endtask

  initial begin
    disp.sec_1s_in  = 4'd1;
    disp.sec_10s_in = 4'd2;
    disp.min_1s_in  = 4'd3;
    disp.min_10s_in = 4'd4;
    disp.adj        = 1'b0;
    disp.sel        = 1'b0;

    // 1: reset state, then first frame shows the cleared snapshot
    @(negedge clk_sel);
    @(negedge clk_sel);
    chk("rst an",  {4'h0, disp.an},  8'h0F);
    chk("rst seg", {1'b0, disp.seg}, 8'h7F);
    chk("rst dp",  {7'h0, disp.dp},  8'h01);
    rst = 1'b0;
    cyc = 0;
    slot("t1 first", 4'b1110, S0, 1'b1, 1);
    slot("t1 s0",    4'b1110, S0, 1'b1, 3);
    slot("t1 s1",    4'b1101, S0, 1'b1, 4);
    slot("t1 s2",    4'b1011, S0, 1'b0, 4);
    slot("t1 s3",    4'b0111, S0, 1'b1, 4);

    // 2: scan of snapshot 1,2,3,4
    slot("t2 s0", 4'b1110, S1, 1'b1, 4);
    slot("t2 s1", 4'b1101, S2, 1'b1, 4);
    slot("t2 s2", 4'b1011, S3, 1'b0, 4);
    slot("t2 s3", 4'b0111, S4, 1'b1, 4);

    // 3: mid-frame change of sec_1s waits for the frame boundary
    slot("t3 s0", 4'b1110, S1, 1'b1, 4);
    slot("t3 s1", 4'b1101, S2, 1'b1, 1);
    disp.sec_1s_in = 4'd7;
    slot("t3 s1b", 4'b1101, S2, 1'b1, 3);
    slot("t3 s2",  4'b1011, S3, 1'b0, 4);
    slot("t3 s3",  4'b0111, S4, 1'b1, 4);
    slot("t3 new", 4'b1110, S7, 1'b1, 4);
    slot("t3 s1c", 4'b1101, S2, 1'b1, 4);

    // 4: blink seconds field
    disp.adj = 1'b1;
    disp.sel = 1'b1;
    slot("t4 vis s2", 4'b1011, S3, 1'b0, 4);
    slot("t4 vis s3", 4'b0111, S4, 1'b1, 4);
    slot("t4 blank",  4'b1111, SD, 1'b1, 8);
    slot("t4 odd s2", 4'b1011, S3, 1'b0, 4);
    slot("t4 odd s3", 4'b0111, S4, 1'b1, 4);
    disp.adj = 1'b0;
    slot("t4 exit s0", 4'b1110, S7, 1'b1, 4);
    disp.min_10s_in = 4'hC;
    slot("t4 exit s1", 4'b1101, S2, 1'b1, 4);
    slot("t4 exit s2", 4'b1011, S3, 1'b0, 4);
    slot("t4 exit s3", 4'b0111, S4, 1'b1, 4);

    // 5: blink minutes field with an invalid digit in min_10s
    disp.adj = 1'b1;
    disp.sel = 1'b0;
    slot("t5 vis s0", 4'b1110, S7, 1'b1, 4);
    slot("t5 vis s1", 4'b1101, S2, 1'b1, 4);
    slot("t5 blank",  4'b1111, SD, 1'b1, 8);
    disp.adj = 1'b0;
    slot("t5 off s0", 4'b1110, S7, 1'b1, 4);
    slot("t5 off s1", 4'b1101, S2, 1'b1, 4);
    disp.adj = 1'b1;
    slot("t5 even s2", 4'b1011, S3, 1'b0, 4);
    slot("t5 even s3", 4'b0111, SD, 1'b1, 4);

    // 6: asynchronous reset while idx==2
    slot("t6 s0", 4'b1110, S7, 1'b1, 4);
    slot("t6 s1", 4'b1101, S2, 1'b1, 4);
    slot("t6 s2", 4'b1011, S3, 1'b0, 1);
    disp.adj = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6 async an",  {4'h0, disp.an},  8'h0F);
    chk("t6 async seg", {1'b0, disp.seg}, 8'h7F);
    chk("t6 async dp",  {7'h0, disp.dp},  8'h01);
    @(negedge clk_sel);
    rst = 1'b0;
    cyc = 0;
    slot("t6 re s0", 4'b1110, S0, 1'b1, 4);
    slot("t6 re s1", 4'b1101, S0, 1'b1, 4);
    slot("t6 re s2", 4'b1011, S0, 1'b0, 4);
    slot("t6 re s3", 4'b0111, S0, 1'b1, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
